// File: rtl/nes_dma_engine_pkg.sv
// Shared types and constants for the OAM-style DMA engine.
package nes_dma_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam int          IDX_W        = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_DUMMY,
    ST_ALIGN,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_PAUSE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/nes_dma_engine_if.sv
// CPU-bus snoop port plus the bus-master port toward the shared arbiter.
interface nes_dma_engine_if;

  // o_dma_req is a level request. The engine owns the bus on every cycle it
  // sees i_dma_gnt=1 while requesting, but it samples i_dma_gnt only in REQ,
  // in PAUSE and at the end of each WRITE. A read/wait/write sequence is never
  // interrupted. i_dma_rdata must be valid RD_LAT cycles after a read address.
  logic [15:0] i_bus_addr;
  logic        i_bus_wn;
  logic [7:0]  i_bus_wdata;
  logic        o_dma_req;
  logic        i_dma_gnt;
  logic [15:0] o_dma_addr;
  logic        o_dma_wn;
  logic [7:0]  o_dma_wdata;
  logic [7:0]  i_dma_rdata;

  modport master (
    input  i_bus_addr, i_bus_wn, i_bus_wdata, i_dma_gnt, i_dma_rdata,
    output o_dma_req, o_dma_addr, o_dma_wn, o_dma_wdata
  );

  modport slave (
    output i_bus_addr, i_bus_wn, i_bus_wdata, i_dma_gnt, i_dma_rdata,
    input  o_dma_req, o_dma_addr, o_dma_wn, o_dma_wdata
  );

endinterface

// File: rtl/nes_dma_engine.sv
// Snoops a trigger write, then copies LEN bytes from page {wdata,idx} to a
// fixed destination register, one read/write pair per byte.
module nes_dma_engine
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = OAMDMA_ADDR,
  parameter logic [15:0] DST_ADDR  = OAMDATA_ADDR,
  parameter int          LEN       = 256,
  parameter int          RD_LAT    = 1,
  parameter bit          ALIGN_EN  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  nes_dma_engine_if.master        bus,
  output logic                    o_busy,
  output logic                    o_done,
  output state_e                  o_dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LEN - 1);
  localparam logic [1:0]       LAT_RELOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       lat_q, lat_d;
  logic [7:0]       page_q, page_d;
  logic             parity_q, parity_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             trig;
  logic [15:0]      dma_addr;
  logic [7:0]       dma_wdata;

  assign trig        = (bus.i_bus_addr == TRIG_ADDR) && !bus.i_bus_wn;
  assign parity_d    = ~parity_q;
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      lat_q    <= '0;
      page_q   <= '0;
      parity_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      lat_q    <= lat_d;
      page_q   <= page_d;
      parity_q <= parity_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    lat_d   = lat_q;
    page_d  = page_q;
    unique case (state_q)
      ST_IDLE: if (trig) begin
        state_d = ST_REQ;
        page_d  = bus.i_bus_wdata;
        index_d = '0;
      end
      ST_REQ:   if (bus.i_dma_gnt) state_d = ST_DUMMY;
      ST_DUMMY: state_d = (ALIGN_EN && parity_q) ? ST_ALIGN : ST_READ;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        lat_d   = LAT_RELOAD;
        state_d = (RD_LAT == 1) ? ST_WRITE : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) state_d = ST_WRITE;
        else               lat_d   = lat_q - 2'd1;
      end
      // Byte boundary: the only place inside a transfer where grant is honoured.
      ST_WRITE: begin
        if (index_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = bus.i_dma_gnt ? ST_READ : ST_PAUSE;
        end
      end
      ST_PAUSE: if (bus.i_dma_gnt) state_d = ST_READ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_dma_req = 1'b0;
    bus.o_dma_wn  = 1'b1;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    dma_addr      = addr_q;
    dma_wdata     = wdata_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_DONE: o_done = 1'b1;
      ST_READ, ST_WAIT: begin
        bus.o_dma_req = 1'b1;
        o_busy        = 1'b1;
        dma_addr      = {page_q, index_q};
      end
      ST_WRITE: begin
        bus.o_dma_req = 1'b1;
        o_busy        = 1'b1;
        bus.o_dma_wn  = 1'b0;
        dma_addr      = DST_ADDR;
        dma_wdata     = bus.i_dma_rdata;
      end
      default: begin
        bus.o_dma_req = 1'b1;
        o_busy        = 1'b1;
      end
    endcase
    bus.o_dma_addr  = dma_addr;
    bus.o_dma_wdata = dma_wdata;
    addr_d          = dma_addr;
    wdata_d         = dma_wdata;
  end

endmodule

// File: doc/nes_dma_engine.md
Name: nes_dma_engine

Overview:
- Parametrised successor to the fixed OAM DMA: snoops CPU writes to a trigger register, then acts as bus master to copy LEN bytes from CPU page {wdata,8'hxx} to a fixed destination register.
- Adds configurable trigger/destination addresses, transfer length, read latency, odd-cycle alignment, grant-pause at byte boundaries, and busy/done status.
- Sits between the CPU bus snoop port and the shared CPU-side bus arbiter.

Parameters:
- TRIG_ADDR, 16'h4014: slave write address that starts a transfer.
- DST_ADDR, 16'h2004: destination address for every write.
- LEN, 256: bytes per transfer. Legal range 1..256; low byte index counts 0..LEN-1.
- RD_LAT, 1: cycles from read address to valid i_dma_rdata. Legal range 1..3.
- ALIGN_EN, 1: 1 inserts one align cycle when the first read would start on an odd cycle.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_bus_addr  in  16  snooped CPU address
- i_bus_wn  in  1  snooped write-not (0 = write)
- i_bus_wdata  in  8  snooped write data (source page)
- o_dma_req  out  1  bus request
- i_dma_gnt  in  1  bus grant
- o_dma_addr  out  16  master address
- o_dma_wn  out  1  master write-not
- o_dma_wdata  out  8  master write data
- i_dma_rdata  in  8  master read data
- o_busy  out  1  high from trigger until completion
- o_done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset values: o_dma_req=0, o_dma_addr=0, o_dma_wn=1, o_dma_wdata=0, o_busy=0, o_done=0. Internal state: IDLE, index=0, parity=0.
- parity toggles every clock from reset; it is 0 in the first cycle after reset release.
- Trigger: in IDLE, i_bus_addr==TRIG_ADDR with i_bus_wn==0 latches page=i_bus_wdata. Next cycle: state REQ, o_busy=1, o_dma_req=1.
- Triggers while o_busy=1 are ignored, including one coincident with the last write.
- States:
  - IDLE: waits for trigger.
  - REQ: holds o_dma_req; goes to DUMMY on the first cycle with i_dma_gnt=1.
  - DUMMY: one cycle, o_dma_wn=1, o_dma_addr=last master address. Goes to ALIGN if ALIGN_EN and parity==1 in this cycle, else READ.
  - ALIGN: one idle cycle, then READ.
  - READ: o_dma_addr={page,index}, o_dma_wn=1.
  - WAIT: RD_LAT-1 cycles, address held. Skipped when RD_LAT=1.
  - WRITE: o_dma_addr=DST_ADDR, o_dma_wn=0, o_dma_wdata=i_dma_rdata (combinational pass-through, registered copy held afterwards). Data is valid by construction: WRITE falls exactly RD_LAT cycles after READ.
  - DONE: one cycle, o_done=1, o_dma_req=0, o_busy=0, then IDLE.
- After WRITE: index++. If index==LEN-1 was just written, go to DONE; else go to READ when i_dma_gnt=1, else PAUSE.
- PAUSE: o_dma_req=1, o_dma_wn=1. Resumes READ on grant with index preserved; no re-DUMMY.
- Grant loss is honoured only at byte boundaries. A READ/WAIT/WRITE sequence is atomic once started, and gnt is ignored inside it.
- Outside WRITE, o_dma_wn=1 always.
- Cycle count from first granted cycle to DONE:
  - 1 + align + LEN*(RD_LAT+1).
  - Defaults: 513 (even) / 514 (odd).
- index width is 8 bits. LEN=256 terminates on index 255 with no wrap into a further read.
- Async reset mid-transfer aborts immediately to reset values with no o_done. The next trigger starts a fresh transfer at index 0.

Decomposition:
- Package nes_dma_pkg:
  - state enum (IDLE, REQ, DUMMY, ALIGN, READ, WAIT, WRITE, PAUSE, DONE)
  - default constants for OAMDMA_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004
  - width localparam for index
- No sub-module: a single FSM with index and latency counters.

Test Plan:
- Defaults, write $4014=8'h02 at even parity, gnt tied 1 -> 256 reads $0200..$02FF alternating with writes to $2004 carrying the read data; o_done exactly 513 cycles after first grant.
- Same trigger timed so DUMMY lands on odd parity -> one ALIGN cycle, 514 cycles; with ALIGN_EN=0 -> 513.
- Grant held low 10 cycles after trigger, then dropped for 5 cycles after byte 37's WRITE -> o_dma_req stays high; transfer resumes at $0226 with no duplicate or missing bytes.
- Second $4014 write mid-transfer with data 8'h03 -> ignored; all addresses stay in page $02.
- LEN=4, RD_LAT=2, page 8'h80 -> reads $8000..$8003, each followed one WAIT cycle later by a write; done after 1+4*3=13 cycles (even).
- i_rstn asserted during byte 100 -> outputs at reset values immediately, no o_done; a retrigger with 8'h05 copies $0500 onward from index 0.
